// File: rtl/cnt_interval_ctrl_pkg.sv
// Shared types and helpers for the interval sequencer and its counter.
package cnt_ctrl_pkg;

  localparam int DEF_WIDTH = 4;
  localparam int DEF_REPW  = 8;

  // state | meaning
  // IDLE  | waiting for a command, cmd_ready high
  // LOAD  | counter load_en asserted with the start value
  // RUN   | counter free-running toward its terminal value
  // DONE  | final interval finished, done pulse visible
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } cnt_ctrl_state_t;

  // Terminal value for a direction: 0 when counting down, all-ones when up.
  function automatic logic [31:0] cnt_terminal(input logic down, input int width);
    if (down) begin
      return 32'd0;
    end
    return (32'd1 << width) - 32'd1;
  endfunction

endpackage

// File: rtl/counter.sv
// Loadable up/down counter; rollover flags the terminal value for the
// current direction and the count wraps on the following edge.
module counter
  import cnt_ctrl_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_en,
  input  logic [WIDTH-1:0] load,
  input  logic             down,
  output logic [WIDTH-1:0] count,
  output logic             rollover
);

  logic [WIDTH-1:0] term;

  assign term     = WIDTH'(cnt_terminal(down, WIDTH));
  assign rollover = (count == term);

  // Count register: clear beats load, load beats counting.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load_en) begin
      count <= load;
    end else if (down) begin
      count <= count - WIDTH'(1);
    end else begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/cnt_interval_ctrl.sv
// Interval sequencer: accepts a command, loads the attached counter and
// reloads it on every rollover for a fixed number of intervals or forever.
module cnt_interval_ctrl
  import cnt_ctrl_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int REPW  = DEF_REPW
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [WIDTH-1:0] cmd_load,
  input  logic             cmd_down,
  input  logic [REPW-1:0]  cmd_reps,
  input  logic             abort,
  output logic             cnt_clr,
  output logic             cnt_load_en,
  output logic [WIDTH-1:0] cnt_load,
  output logic             cnt_down,
  input  logic [WIDTH-1:0] cnt_count,
  input  logic             cnt_rollover,
  output logic             busy,
  output logic             tick,
  output logic             done,
  output logic [REPW-1:0]  reps_left
);

  cnt_ctrl_state_t  state, state_nx;
  logic [WIDTH-1:0] cfg_load, cfg_load_nx;
  logic             cfg_down, cfg_down_nx;
  logic [REPW-1:0]  cfg_reps, cfg_reps_nx;
  logic [REPW-1:0]  reps_nx;
  logic             tick_nx;
  logic             done_nx;
  logic             clr_nx;
  logic             periodic;

  // The count is observed only by software/debug; the sequencer relies on
  // rollover alone.
  logic unused_count;
  assign unused_count = ^cnt_count;

  assign periodic = (cfg_reps == '0);
  assign busy     = (state != IDLE);

  // State, configuration, repetition and pulse registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cfg_load  <= '0;
      cfg_down  <= 1'b0;
      cfg_reps  <= '0;
      reps_left <= '0;
      tick      <= 1'b0;
      done      <= 1'b0;
      cnt_clr   <= 1'b1;
    end else begin
      state     <= state_nx;
      cfg_load  <= cfg_load_nx;
      cfg_down  <= cfg_down_nx;
      cfg_reps  <= cfg_reps_nx;
      reps_left <= reps_nx;
      tick      <= tick_nx;
      done      <= done_nx;
      cnt_clr   <= clr_nx;
    end
  end

  // Next-state, next register values and counter control outputs.
  always_comb begin
    state_nx    = state;
    cfg_load_nx = cfg_load;
    cfg_down_nx = cfg_down;
    cfg_reps_nx = cfg_reps;
    reps_nx     = reps_left;
    tick_nx     = 1'b0;
    done_nx     = 1'b0;
    clr_nx      = 1'b0;
    cmd_ready   = 1'b0;
    cnt_load_en = 1'b0;
    cnt_load    = '0;
    cnt_down    = 1'b0;

    case (state)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          cfg_load_nx = cmd_load;
          cfg_down_nx = cmd_down;
          cfg_reps_nx = cmd_reps;
          // cmd_reps of zero selects periodic mode, which keeps reps_left at 0.
          reps_nx     = cmd_reps;
          state_nx    = LOAD;
        end
      end
      LOAD: begin
        cnt_load_en = 1'b1;
        cnt_load    = cfg_load;
        cnt_down    = cfg_down;
        state_nx    = RUN;
      end
      RUN: begin
        cnt_down = cfg_down;
        if (cnt_rollover) begin
          tick_nx = 1'b1;
          if (periodic) begin
            state_nx = LOAD;
          end else if (reps_left > REPW'(1)) begin
            reps_nx  = reps_left - REPW'(1);
            state_nx = LOAD;
          end else begin
            reps_nx  = '0;
            done_nx  = 1'b1;
            state_nx = DONE;
          end
        end
      end
      DONE: begin
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase

    // Abort wins over a coincident rollover and clears the counter once.
    if (abort && (state != IDLE)) begin
      state_nx = IDLE;
      reps_nx  = '0;
      tick_nx  = 1'b0;
      done_nx  = 1'b0;
      clr_nx   = 1'b1;
    end
  end

endmodule

// File: tb/tb_cnt_interval_ctrl.sv
// Scoreboard bench for the interval sequencer driving a real counter.
module tb_cnt_interval_ctrl;

  localparam int WIDTH = 4;
  localparam int REPW  = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [WIDTH-1:0] cmd_load;
  logic             cmd_down;
  logic [REPW-1:0]  cmd_reps;
  logic             abort;
  logic             cnt_clr;
  logic             cnt_load_en;
  logic [WIDTH-1:0] cnt_load;
  logic             cnt_down;
  logic [WIDTH-1:0] cnt_count;
  logic             cnt_rollover;
  logic             busy;
  logic             tick;
  logic             done;
  logic [REPW-1:0]  reps_left;

  cnt_interval_ctrl #(.WIDTH(WIDTH), .REPW(REPW)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_load(cmd_load), .cmd_down(cmd_down), .cmd_reps(cmd_reps),
    .abort(abort),
    .cnt_clr(cnt_clr), .cnt_load_en(cnt_load_en), .cnt_load(cnt_load),
    .cnt_down(cnt_down), .cnt_count(cnt_count), .cnt_rollover(cnt_rollover),
    .busy(busy), .tick(tick), .done(done), .reps_left(reps_left)
  );

  counter #(.WIDTH(WIDTH)) u_cnt (
    .clk(clk), .rst(cnt_clr), .load_en(cnt_load_en), .load(cnt_load),
    .down(cnt_down), .count(cnt_count), .rollover(cnt_rollover)
  );

  typedef struct {
    int             cyc;
    logic [REPW-1:0] reps;
    logic           dn;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic void push(input int c, input int reps, input logic dn);
    exp_t e;
    e.cyc  = c;
    e.reps = REPW'(reps);
    e.dn   = dn;
    sb.push_back(e);
  endfunction

  // Monitor: every tick/done pulse must match the oldest expected event.
  always @(negedge clk) begin
    if (!rst && (tick === 1'b1 || done === 1'b1)) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_pulse cycle=%0d tick=%0b done=%0b expected none", cyc, tick, done);
      end else begin
        mon_e = sb.pop_front();
        chk("tick_cycle", cyc, mon_e.cyc);
        chk("tick_present", {31'd0, tick}, 32'd1);
        chk("tick_reps_left", {24'd0, reps_left}, {24'd0, mon_e.reps});
        chk("tick_done", {31'd0, done}, {31'd0, mon_e.dn});
      end
    end
  end

  task automatic wait_cyc(input int target);
    int g;
    g = 0;
    while (cyc < target && g < 2000) begin
      @(negedge clk);
      g++;
    end
    if (cyc != target) begin
      total++;
      bad++;
      $display("FAIL wait_cyc actual=%0d expected=%0d", cyc, target);
    end
  endtask

  // Offer a command from a negedge and hold it until accepted; k0 is the
  // cycle index of the resulting LOAD cycle.
  task automatic send(input logic [WIDTH-1:0] ld, input logic dn, input logic [REPW-1:0] rp,
                      input logic ab, output int k0);
    logic rdy;
    k0        = -1;
    cmd_load  = ld;
    cmd_down  = dn;
    cmd_reps  = rp;
    cmd_valid = 1'b1;
    abort     = ab;
    for (int g = 0; g < 100; g++) begin
      rdy = cmd_ready;
      @(negedge clk);
      if (rdy) begin
        k0 = cyc;
        break;
      end
    end
    cmd_valid = 1'b0;
    abort     = 1'b0;
    if (k0 < 0) begin
      total++;
      bad++;
      $display("FAIL send_timeout actual=not_accepted expected=accepted");
    end
  endtask

  initial begin
    int k, ka, kb, g;
    rst       = 1'b1;
    cmd_valid = 1'b0;
    cmd_load  = '0;
    cmd_down  = 1'b0;
    cmd_reps  = '0;
    abort     = 1'b0;

    // Reset
    repeat (2) @(negedge clk);
    chk("rst_cnt_clr", {31'd0, cnt_clr}, 32'd1);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    chk("rst_tick_done", {30'd0, tick, done}, 32'd0);
    chk("rst_load_outs", {26'd0, cnt_load_en, cnt_down, cnt_load}, 32'd0);
    chk("rst_reps_left", {24'd0, reps_left}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("rel_cnt_clr", {31'd0, cnt_clr}, 32'd0);

    // Up, single interval from 0xD
    send(4'hD, 1'b0, 8'd1, 1'b0, k);
    push(k + 4, 0, 1'b1);
    chk("up_load_en", {31'd0, cnt_load_en}, 32'd1);
    chk("up_load_val", {28'd0, cnt_load}, 32'hD);
    wait_cyc(k + 1);
    chk("up_count_d", {28'd0, cnt_count}, 32'hD);
    chk("up_reps_left", {24'd0, reps_left}, 32'd1);
    wait_cyc(k + 2);
    chk("up_count_e", {28'd0, cnt_count}, 32'hE);
    wait_cyc(k + 3);
    chk("up_count_f", {28'd0, cnt_count}, 32'hF);
    wait_cyc(k + 5);
    chk("up_idle_busy", {31'd0, busy}, 32'd0);
    chk("up_idle_ready", {31'd0, cmd_ready}, 32'd1);

    // Down from 2, three intervals
    send(4'h2, 1'b1, 8'd3, 1'b0, k);
    push(k + 4, 2, 1'b0);
    push(k + 8, 1, 1'b0);
    push(k + 12, 0, 1'b1);
    chk("dn_cnt_down", {31'd0, cnt_down}, 32'd1);
    wait_cyc(k + 1);
    chk("dn_count_2", {28'd0, cnt_count}, 32'h2);
    chk("dn_reps_3", {24'd0, reps_left}, 32'd3);
    wait_cyc(k + 3);
    chk("dn_count_0", {28'd0, cnt_count}, 32'h0);
    chk("dn_rollover", {31'd0, cnt_rollover}, 32'd1);
    wait_cyc(k + 5);
    chk("dn_reload_2", {28'd0, cnt_count}, 32'h2);
    wait_cyc(k + 14);
    chk("dn_idle_busy", {31'd0, busy}, 32'd0);

    // Periodic from 0xE, abort on a rollover cycle
    send(4'hE, 1'b0, 8'd0, 1'b0, k);
    push(k + 3, 0, 1'b0);
    push(k + 6, 0, 1'b0);
    wait_cyc(k + 8);
    chk("per_rollover", {31'd0, cnt_rollover}, 32'd1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_clr", {31'd0, cnt_clr}, 32'd1);
    chk("abort_tick", {31'd0, tick}, 32'd0);
    chk("abort_reps", {24'd0, reps_left}, 32'd0);
    @(negedge clk);
    chk("abort_clr_end", {31'd0, cnt_clr}, 32'd0);
    chk("abort_count_clr", {28'd0, cnt_count}, 32'd0);

    // Boundary: up from all-ones, two intervals
    send(4'hF, 1'b0, 8'd2, 1'b0, k);
    push(k + 2, 1, 1'b0);
    push(k + 4, 0, 1'b1);
    wait_cyc(k + 5);
    chk("bnd_up_idle", {31'd0, busy}, 32'd0);

    // Boundary: down from 0, with abort held during the accept cycle
    send(4'h0, 1'b1, 8'd2, 1'b1, k);
    push(k + 2, 1, 1'b0);
    push(k + 4, 0, 1'b1);
    chk("bnd_dn_load", {31'd0, cnt_load_en}, 32'd1);
    wait_cyc(k + 5);
    chk("bnd_dn_idle", {31'd0, busy}, 32'd0);

    // Handshake: second command held during the first one's RUN
    send(4'h1, 1'b1, 8'd1, 1'b0, ka);
    push(ka + 3, 0, 1'b1);
    wait_cyc(ka + 1);
    chk("hs_ready_run", {31'd0, cmd_ready}, 32'd0);
    send(4'hC, 1'b0, 8'd1, 1'b0, kb);
    chk("hs_accept_cycle", kb, ka + 5);
    push(kb + 5, 0, 1'b1);
    wait_cyc(kb + 6);
    chk("hs_idle", {31'd0, busy}, 32'd0);

    // Reset in the middle of RUN
    send(4'h5, 1'b1, 8'd2, 1'b0, k);
    wait_cyc(k + 2);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    chk("mid_rst_clr", {31'd0, cnt_clr}, 32'd1);
    chk("mid_rst_outs", {24'd0, tick, done, cnt_load_en, cnt_down, cnt_load}, 32'd0);
    chk("mid_rst_reps", {24'd0, reps_left}, 32'd0);
    chk("mid_rst_ready", {31'd0, cmd_ready}, 32'd1);
    rst = 1'b0;
    @(negedge clk);
    chk("mid_rel_clr", {31'd0, cnt_clr}, 32'd0);
    chk("mid_rel_count", {28'd0, cnt_count}, 32'd0);

    g = 0;
    while (sb.size() != 0 && g < 50) begin
      @(negedge clk);
      g++;
    end
    chk("sb_drained", sb.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
